mhsa_host_loader: RTL
=====================

Name: mhsa_host_loader

Overview:
- Host-side sequencer upstream of the MHSA accelerator wrapper; drives its unified SRAM port, start, input_base and output_base.
- Per command it runs four phases: stream-loads input words into the bar memory map, runs the accelerator, waits for done, then reads a result window back out as a stream.
- Replaces ad-hoc bench/SoC sequencing with one handshaked block.

Parameters:
- WIDTH, 64, data word width; matches the accelerator memory width.
- LEN_W, 16, width of the word-count fields.
- TIMEOUT, 1000000, maximum cycles in WAIT_DONE before abort.
- MAP_LIMIT, 32'h0000_4000, first address past the bar0..bar3 map.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_load_addr  in  32  first SRAM word address to write.
- cmd_load_len  in  LEN_W  words to load; 0 skips LOAD.
- cmd_rd_addr  in  32  first result word address.
- cmd_rd_len  in  LEN_W  words to read back; 0 skips READ.
- cmd_input_base  in  32  forwarded to acc_input_base.
- cmd_output_base  in  32  forwarded to acc_output_base.
- in_valid  in  1  load-stream valid.
- in_ready  out  1  load-stream ready.
- in_data  in  WIDTH  load word.
- out_valid  out  1  result-stream valid.
- out_ready  in  1  result-stream ready.
- out_data  out  WIDTH  result word.
- acc_start  out  1  level start to the wrapper; held for the whole run.
- acc_done  in  1  done from the wrapper (level or pulse).
- acc_input_base  out  32  registered copy of cmd_input_base.
- acc_output_base  out  32  registered copy of cmd_output_base.
- soc_write_en  out  1  SRAM write enable.
- soc_data_in  out  WIDTH  SRAM write data.
- soc_addr  out  32  SRAM address.
- soc_data_out  in  WIDTH  SRAM read data; valid 1 cycle after its address.
- busy  out  1  high whenever the state is not IDLE.
- err  out  1  one-cycle pulse on a range error or timeout.

Behaviour:

Reset:
- All outputs are 0, except cmd_ready, which is 1 (the FSM is in IDLE).
- The FSM returns to IDLE, counters clear, and the skid buffer empties.
- A reset in any state, including mid-run, drops acc_start on the next edge.

FSM states and transitions:
- IDLE:
  - On cmd_valid&cmd_ready, latch all cmd fields; acc_*_base update the same edge.
  - Range check: load_addr+load_len > MAP_LIMIT, or rd_addr+rd_len > MAP_LIMIT, computed in 33 bits so there is no wrap.
  - If the check fails: pulse err, stay in IDLE, issue no SRAM access.
  - Otherwise go to LOAD, or to RUN when load_len==0.
- LOAD:
  - in_ready = 1.
  - On each in_valid&in_ready: soc_write_en=1, soc_addr=load_addr+cnt, soc_data_in=in_data (combinational from in_data), then cnt++.
  - The beat where cnt==load_len-1 goes to RUN.
  - Each write takes exactly one cycle; there is no SRAM backpressure.
- RUN: assert acc_start and go to WAIT_DONE the next cycle. While acc_start=1, soc_write_en=0 and soc_addr=0.
- WAIT_DONE:
  - acc_start stays 1; a timer counts up.
  - When acc_done=1 is sampled: acc_start=0 the next cycle, then go to READ, or to IDLE when rd_len==0.
  - When the timer reaches TIMEOUT: drop acc_start, pulse err, go to IDLE. The result read is skipped.
  - acc_done seen in any other state is ignored.
- READ:
  - Issue a read (soc_write_en=0, soc_addr=rd_addr+issue_cnt) only when the in-flight count plus the skid-buffer occupancy is < 2.
  - Each returned soc_data_out is pushed into the skid buffer exactly 1 cycle after its issue.
  - After rd_len issues and rd_len pops at out_valid&out_ready, go to IDLE.

Output stream rules:
- out_data is held stable while out_valid&!out_ready.
- The output order equals address order.
- If out_ready is held high, throughput is 1 word/cycle after a 2-cycle first-word latency from entering READ.

Boundary conditions:
- A command presented while busy is not accepted.
- in_valid outside LOAD is ignored.
- A load exactly ending at MAP_LIMIT-1 is legal.
- A run with load_len==0 and rd_len==0 only runs the accelerator.
- acc_done already high at RUN entry is sampled in WAIT_DONE on the first cycle.

Decomposition:
- Package mhsa_pkg holds:
  - the state enum (IDLE, LOAD, RUN, WAIT_DONE, READ);
  - the bar base constants 0x0000/0x1000/0x2000/0x3000 and MAP_LIMIT;
  - a cmd struct typedef.
- Sub-module mhsa_skid_buf: 2-entry valid/ready buffer with an occupancy output, used by the READ path.

Test Plan:
- Load 4 words 0x11..0x14 at 0x0000 with in_valid toggled every other cycle -> soc writes at addresses 0..3 with matching data, one write per accepted beat, then acc_start rises.
- acc_done asserted 10 cycles after acc_start -> acc_start falls the cycle after done is sampled; with rd_len=3 at 0x3000, out_data shows mem[0x3000..0x3002] in order.
- Drain with out_ready low for 5 cycles mid-stream -> at most 2 reads outstanding, no lost or duplicated word, out_data stable while stalled.
- Command with load_addr=0x3FFE, load_len=4 -> err pulse, no soc_write_en, busy stays 0, cmd_ready stays 1.
- TIMEOUT=50, acc_done never asserted -> acc_start drops and err pulses at cycle 50 of WAIT_DONE; FSM back in IDLE, next command accepted.
- rst asserted in WAIT_DONE -> the next cycle has acc_start=0, busy=0, cmd_ready=1, out_valid=0.

Source files
------------

// File: rtl/mhsa_pkg.sv
// Shared types and constants for the MHSA host loader: FSM states, the bar
// memory map and the latched command record.
package mhsa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        WAIT_DONE,
        READ
    } state_t;

    localparam logic [31:0] BAR0_BASE     = 32'h0000_0000;
    localparam logic [31:0] BAR1_BASE     = 32'h0000_1000;
    localparam logic [31:0] BAR2_BASE     = 32'h0000_2000;
    localparam logic [31:0] BAR3_BASE     = 32'h0000_3000;
    localparam logic [31:0] BAR_MAP_LIMIT = BAR0_BASE + 32'h0000_4000;

    // Word counts are held zero-extended to 32 bits so they add directly
    // to the 32-bit addresses.
    typedef struct packed {
        logic [31:0] load_addr;
        logic [31:0] load_len;
        logic [31:0] rd_addr;
        logic [31:0] rd_len;
    } cmd_t;

    // True when [addr, addr+len) runs past limit; 33-bit sum so it cannot wrap.
    function automatic logic range_bad(input logic [31:0] addr,
                                       input logic [31:0] len,
                                       input logic [31:0] limit);
        return ({1'b0, addr} + {1'b0, len}) > {1'b0, limit};
    endfunction

    // Which bar an address falls in.
    function automatic logic [1:0] bar_select(input logic [31:0] addr);
        if (addr >= BAR3_BASE)      return 2'd3;
        else if (addr >= BAR2_BASE) return 2'd2;
        else if (addr >= BAR1_BASE) return 2'd1;
        else                        return 2'd0;
    endfunction

endpackage

// File: rtl/mhsa_skid_buf.sv
// Two-entry valid/ready buffer for returning SRAM read data. The producer
// guarantees it never pushes into a full buffer, so push has no ready.
module mhsa_skid_buf
    import mhsa_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       cnt_q;
    logic             pop;

    assign out_valid = (cnt_q != 2'd0);
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign occupancy = cnt_q;

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage, written on push; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/mhsa_host_loader.sv
// Host-side sequencer for the MHSA accelerator: loads input words into the
// bar map, runs the accelerator, waits for done, then streams results out.
module mhsa_host_loader
    import mhsa_pkg::*;
#(
    parameter int          WIDTH     = 64,
    parameter int          LEN_W     = 16,
    parameter int          TIMEOUT   = 1000000,
    parameter logic [31:0] MAP_LIMIT = BAR_MAP_LIMIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_load_addr,
    input  logic [LEN_W-1:0] cmd_load_len,
    input  logic [31:0]      cmd_rd_addr,
    input  logic [LEN_W-1:0] cmd_rd_len,
    input  logic [31:0]      cmd_input_base,
    input  logic [31:0]      cmd_output_base,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             acc_start,
    input  logic             acc_done,
    output logic [31:0]      acc_input_base,
    output logic [31:0]      acc_output_base,
    output logic             soc_write_en,
    output logic [WIDTH-1:0] soc_data_in,
    output logic [31:0]      soc_addr,
    input  logic [WIDTH-1:0] soc_data_out,
    output logic             busy,
    output logic             err
);

    state_t      state_q, state_d;
    cmd_t        cmd_q;
    logic [31:0] cnt_q;
    logic [31:0] timer_q;
    logic [31:0] issue_cnt_q;
    logic [31:0] pop_cnt_q;
    logic        vld_p1;
    logic        err_q;
    logic        cmd_bad;
    logic        rd_issue;
    logic        pop;
    logic [1:0]  occ;
    logic [1:0]  slot_used;

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign acc_start = (state_q == RUN) || (state_q == WAIT_DONE);
    assign err       = err_q;
    assign pop       = out_valid & out_ready;
    assign slot_used = {1'b0, vld_p1} + occ;

    assign cmd_bad = range_bad(cmd_load_addr, 32'(cmd_load_len), MAP_LIMIT) |
                     range_bad(cmd_rd_addr,   32'(cmd_rd_len),   MAP_LIMIT);

    // Next state plus the combinational SRAM port and load handshake.
    always_comb begin
        state_d      = state_q;
        in_ready     = 1'b0;
        soc_write_en = 1'b0;
        soc_addr     = '0;
        soc_data_in  = '0;
        rd_issue     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && !cmd_bad)
                    state_d = (cmd_load_len == '0) ? RUN : LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    soc_write_en = 1'b1;
                    soc_addr     = cmd_q.load_addr + cnt_q;
                    soc_data_in  = in_data;
                    if (cnt_q == cmd_q.load_len - 32'd1) state_d = RUN;
                end
            end
            RUN: state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (acc_done)
                    state_d = (cmd_q.rd_len == 32'd0) ? IDLE : READ;
                else if (timer_q == 32'(TIMEOUT - 1))
                    state_d = IDLE;
            end
            READ: begin
                // A slot freed by this cycle's pop may be reused at once,
                // which keeps one word per cycle when out_ready stays high.
                if ((issue_cnt_q != cmd_q.rd_len) && ((slot_used < 2'd2) || pop)) begin
                    rd_issue = 1'b1;
                    soc_addr = cmd_q.rd_addr + issue_cnt_q;
                end
                if (pop && (pop_cnt_q == cmd_q.rd_len - 32'd1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters, error pulse, accelerator base registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            timer_q         <= '0;
            issue_cnt_q     <= '0;
            pop_cnt_q       <= '0;
            vld_p1          <= 1'b0;
            err_q           <= 1'b0;
            acc_input_base  <= '0;
            acc_output_base <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= 1'b0;
            vld_p1  <= rd_issue;
            case (state_q)
                IDLE: begin
                    cnt_q       <= '0;
                    timer_q     <= '0;
                    issue_cnt_q <= '0;
                    pop_cnt_q   <= '0;
                    if (cmd_valid) begin
                        acc_input_base  <= cmd_input_base;
                        acc_output_base <= cmd_output_base;
                        if (cmd_bad) err_q <= 1'b1;
                    end
                end
                LOAD: if (in_valid) cnt_q <= cnt_q + 32'd1;
                WAIT_DONE: begin
                    timer_q <= timer_q + 32'd1;
                    if (!acc_done && (timer_q == 32'(TIMEOUT - 1))) err_q <= 1'b1;
                end
                READ: begin
                    if (rd_issue) issue_cnt_q <= issue_cnt_q + 32'd1;
                    if (pop)      pop_cnt_q   <= pop_cnt_q + 32'd1;
                end
                default: ;
            endcase
        end
    end

    // Command capture on acceptance.
    always_ff @(posedge clk) begin
        if (cmd_valid && cmd_ready)
            cmd_q <= '{load_addr: cmd_load_addr, load_len: 32'(cmd_load_len),
                       rd_addr: cmd_rd_addr, rd_len: 32'(cmd_rd_len)};
    end

    // ---- read return stage: SRAM data arrives one cycle after issue ----
    mhsa_skid_buf #(.WIDTH(WIDTH)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (vld_p1),
        .push_data (soc_data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occ)
    );

endmodule
